// File: rtl/ifmap_diag_loader_pkg.sv
// Shared definitions for the ifmap diagonal loader: default widths,
// FSM state encoding and the configuration sanity helper.
package ifmap_diag_loader_pkg;

  localparam int DW_DEFAULT    = 16;
  localparam int NDIAG_DEFAULT = 25;
  localparam int AW_DEFAULT    = 14;
  localparam int CW_DEFAULT    = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_OUT   = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  // A run with no rows, no channels, no filter columns, or a filter wider
  // than the ifmap has no work to do.
  function automatic logic cfg_degenerate(input logic [15:0] h,
                                          input logic [15:0] w,
                                          input logic [15:0] s,
                                          input logic [15:0] q,
                                          input logic [15:0] r);
    return (h == 16'd0) || (q == 16'd0) || (r == 16'd0) ||
           (s == 16'd0) || (s > w);
  endfunction

endpackage

// File: rtl/ifmap_addr_gen.sv
// Ifmap bank address generator. The address
//   cr*q*H*W + cq*H*W + h*W + cs + col
// is kept as a sum of independently stepped offsets so that no multiply
// is needed while a run is in progress; H*W is formed once at start.
module ifmap_addr_gen
  import ifmap_diag_loader_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic [15:0]   h_cfg,
  input  logic [15:0]   w_cfg,
  input  logic          row_step,
  input  logic          row_last,
  input  logic          adv,
  input  logic          cq_wrap,
  input  logic          cs_wrap,
  input  logic          cr_wrap,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] hw;
  logic [AW-1:0] w_step;
  logic [AW-1:0] cr_base;
  logic [AW-1:0] cq_off;
  logic [AW-1:0] row_off;
  logic [AW-1:0] cs_off;
  logic [AW-1:0] col_off;

  // Offset registers; every sum wraps modulo 2^AW like the final address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw      <= '0;
      w_step  <= '0;
      cr_base <= '0;
      cq_off  <= '0;
      row_off <= '0;
      cs_off  <= '0;
      col_off <= '0;
    end else if (init) begin
      hw      <= AW'(h_cfg * w_cfg);
      w_step  <= AW'(w_cfg);
      cr_base <= '0;
      cq_off  <= '0;
      row_off <= '0;
      cs_off  <= '0;
      col_off <= '0;
    end else begin
      if (row_step) begin
        row_off <= row_last ? '0 : row_off + w_step;
      end
      if (adv) begin
        if (!cq_wrap) begin
          cq_off <= cq_off + hw;
        end else begin
          cq_off <= '0;
          if (!cs_wrap) begin
            cs_off <= cs_off + ONE;
          end else begin
            cs_off <= '0;
            // cq_off holds (q-1)*H*W here, so adding one more H*W steps
            // the channel-set base by q*H*W without a q multiply.
            if (!cr_wrap) begin
              cr_base <= cr_base + cq_off + hw;
            end else begin
              cr_base <= '0;
              col_off <= col_off + ONE;
            end
          end
        end
      end
    end
  end

  // Address is the running sum of all offsets.
  always_comb begin
    addr = cr_base + cq_off + row_off + cs_off + col_off;
  end

endmodule

// File: rtl/ifmap_diag_loader.sv
// Ifmap diagonal loader: walks the (col, cr, cs, cq) tuple space, reads H
// ifmap rows per tuple and presents them as one beat on the PE-array
// diagonals, row h of channel-set cr landing on diagonal cr*R + h.
module ifmap_diag_loader
  import ifmap_diag_loader_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int NDIAG = NDIAG_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int CW    = CW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         H,
  input  logic [15:0]         W,
  input  logic [CW-1:0]       S,
  input  logic [CW-1:0]       R,
  input  logic [CW-1:0]       q,
  input  logic [CW-1:0]       r,
  output logic                mem_en,
  output logic [AW-1:0]       mem_addr,
  input  logic [DW-1:0]       mem_rdata,
  output logic [NDIAG*DW-1:0] diag_data,
  output logic [NDIAG-1:0]    diag_valid,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  // Wide enough for cr*R + h with any CW and a 16-bit h.
  localparam int KW = 2 * CW + 17;

  state_t        state;
  logic [15:0]   cfg_h;
  logic [15:0]   cfg_w;
  logic [CW-1:0] cfg_s;
  logic [CW-1:0] cfg_rows;
  logic [CW-1:0] cfg_q;
  logic [CW-1:0] cfg_r;
  logic [15:0]   col;
  logic [CW-1:0] cr;
  logic [CW-1:0] cs;
  logic [CW-1:0] cq;
  logic [15:0]   h_cnt;
  logic [KW-1:0] kbase;
  logic          rd_pending;
  logic [KW-1:0] rd_k;

  logic          degen;
  logic          start_acc;
  logic          row_step;
  logic          row_last;
  logic          hs;
  logic          cq_wrap;
  logic          cs_wrap;
  logic          cr_wrap;
  logic          col_last;
  logic [AW-1:0] gen_addr;

  // Loop-bound detection and handshake qualification.
  always_comb begin
    degen     = cfg_degenerate(H, W, 16'(S), 16'(q), 16'(r));
    start_acc = (state == ST_IDLE) && start;
    row_step  = (state == ST_FETCH) && !abort;
    row_last  = (h_cnt == cfg_h - 16'd1);
    hs        = (state == ST_OUT) && out_ready && !abort;
    cq_wrap   = (cq == cfg_q - CW'(1));
    cs_wrap   = (cs == cfg_s - CW'(1));
    cr_wrap   = (cr == cfg_r - CW'(1));
    col_last  = (col == cfg_w - 16'(cfg_s));
  end

  ifmap_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (start_acc),
    .h_cfg    (H),
    .w_cfg    (W),
    .row_step (row_step),
    .row_last (row_last),
    .adv      (hs),
    .cq_wrap  (cq_wrap),
    .cs_wrap  (cs_wrap),
    .cr_wrap  (cr_wrap),
    .addr     (gen_addr)
  );

  // Status and bank strobe decode from the state; all zero in IDLE/reset.
  always_comb begin
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_OUT);
    mem_en    = (state == ST_FETCH);
    mem_addr  = (state == ST_FETCH) ? gen_addr : '0;
  end

  // FSM, tuple counters, read-return capture and diagonal register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cfg_h      <= '0;
      cfg_w      <= '0;
      cfg_s      <= '0;
      cfg_rows   <= '0;
      cfg_q      <= '0;
      cfg_r      <= '0;
      col        <= '0;
      cr         <= '0;
      cs         <= '0;
      cq         <= '0;
      h_cnt      <= '0;
      kbase      <= '0;
      rd_pending <= 1'b0;
      rd_k       <= '0;
      diag_data  <= '0;
      diag_valid <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      // Read data returns one cycle after the strobe; remember its target.
      rd_pending <= (state == ST_FETCH) && !abort;
      rd_k       <= kbase + KW'(h_cnt);

      if (rd_pending && !abort) begin
        if (rd_k >= KW'(NDIAG)) begin
          cfg_err <= 1'b1;
        end else begin
          for (int unsigned i = 0; i < NDIAG; i++) begin
            if (rd_k == KW'(i)) begin
              diag_data[i*DW +: DW] <= mem_rdata;
              diag_valid[i]         <= 1'b1;
            end
          end
        end
      end

      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_h      <= H;
              cfg_w      <= W;
              cfg_s      <= S;
              cfg_rows   <= R;
              cfg_q      <= q;
              cfg_r      <= r;
              col        <= '0;
              cr         <= '0;
              cs         <= '0;
              cq         <= '0;
              h_cnt      <= '0;
              kbase      <= '0;
              diag_data  <= '0;
              diag_valid <= '0;
              cfg_err    <= degen;
              state      <= degen ? ST_FIN : ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (row_last) begin
              h_cnt <= '0;
              state <= ST_DRAIN;
            end else begin
              h_cnt <= h_cnt + 16'd1;
            end
          end
          ST_DRAIN: begin
            state <= ST_OUT;
          end
          ST_OUT: begin
            if (out_ready) begin
              if (cq_wrap && cs_wrap && cr_wrap && col_last) begin
                state <= ST_FIN;
              end else begin
                state      <= ST_FETCH;
                diag_data  <= '0;
                diag_valid <= '0;
              end
              if (!cq_wrap) begin
                cq <= cq + CW'(1);
              end else begin
                cq <= '0;
                if (!cs_wrap) begin
                  cs <= cs + CW'(1);
                end else begin
                  cs <= '0;
                  if (!cr_wrap) begin
                    cr    <= cr + CW'(1);
                    kbase <= kbase + KW'(cfg_rows);
                  end else begin
                    cr    <= '0;
                    kbase <= '0;
                    col   <= col + 16'd1;
                  end
                end
              end
            end
          end
          ST_FIN: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifmap_diag_loader.sv
// Directed bench for ifmap_diag_loader; the ifmap bank returns its own
// address as data one cycle after each read strobe.
module tb_ifmap_diag_loader;

  localparam int DW    = 16;
  localparam int NDIAG = 25;
  localparam int AW    = 14;
  localparam int CW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic [15:0]         H;
  logic [15:0]         W;
  logic [CW-1:0]       S;
  logic [CW-1:0]       R;
  logic [CW-1:0]       q;
  logic [CW-1:0]       r;
  logic                mem_en;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_rdata = '0;
  logic [NDIAG*DW-1:0] diag_data;
  logic [NDIAG-1:0]    diag_valid;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
  logic                cfg_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int memen_cnt = 0;
  int lat;
  int d0;
  int m0;
  int t1_base [6] = '{0, 1, 1, 2, 2, 3};

  always #5 clk = ~clk;

  ifmap_diag_loader #(
    .DW(DW),
    .NDIAG(NDIAG),
    .AW(AW),
    .CW(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .H          (H),
    .W          (W),
    .S          (S),
    .R          (R),
    .q          (q),
    .r          (r),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .diag_data  (diag_data),
    .diag_valid (diag_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  // memory[i] = i
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= DW'(mem_addr);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_en) memen_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dg(input int k);
    return diag_data[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int hh, input int ww, input int ss, input int rr_f,
                           input int qq, input int rr);
    H = 16'(hh); W = 16'(ww); S = CW'(ss); R = CW'(rr_f); q = CW'(qq); r = CW'(rr);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beat(output int l);
    l = 0;
    do begin
      tick();
      l++;
    end while (!out_valid && l < 200);
    chk("beat_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    H = '0; W = '0; S = '0; R = '0; q = '0; r = '0;
    tick();
    tick();
    chk("rst_status", {59'd0, busy, mem_en, out_valid, done, cfg_err}, 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_dvalid", 64'(diag_valid), 64'd0);
    rst = 1'b0;
    tick();

    // Basic run: 3 columns x 2 filter columns = 6 beats.
    d0 = done_cnt; m0 = memen_cnt;
    start_run(3, 4, 2, 3, 1, 1);
    for (int b = 0; b < 6; b++) begin
      wait_beat(lat);
      if (b == 0) chk("t1_latency", 64'(lat), 64'd4);
      chk($sformatf("t1_b%0d_d0", b), 64'(dg(0)), 64'(t1_base[b]));
      chk($sformatf("t1_b%0d_d1", b), 64'(dg(1)), 64'(t1_base[b] + 4));
      chk($sformatf("t1_b%0d_d2", b), 64'(dg(2)), 64'(t1_base[b] + 8));
      chk($sformatf("t1_b%0d_valid", b), 64'(diag_valid), 64'h7);
    end
    wait_idle();
    tick();
    tick();
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_reads", 64'(memen_cnt - m0), 64'd18);
    chk("t1_cfg_err", 64'(cfg_err), 64'd0);

    // Two channel sets of two channels: 3 cols x 2 cr x 2 cs x 2 cq = 24 beats.
    d0 = done_cnt; m0 = memen_cnt;
    start_run(3, 4, 2, 3, 2, 2);
    for (int b = 0; b < 24; b++) begin
      wait_beat(lat);
      if (b == 1) begin
        chk("t2_b1_d0", 64'(dg(0)), 64'd12);
        chk("t2_b1_d2", 64'(dg(2)), 64'd20);
        chk("t2_b1_valid", 64'(diag_valid), 64'h7);
      end
      if (b == 4) begin
        chk("t2_b4_d3", 64'(dg(3)), 64'd24);
        chk("t2_b4_d4", 64'(dg(4)), 64'd28);
        chk("t2_b4_d5", 64'(dg(5)), 64'd32);
        chk("t2_b4_d0", 64'(dg(0)), 64'd0);
        chk("t2_b4_valid", 64'(diag_valid), 64'h38);
      end
      if (b == 7) begin
        chk("t2_b7_d3", 64'(dg(3)), 64'd37);
        chk("t2_b7_d5", 64'(dg(5)), 64'd45);
      end
      if (b == 8) begin
        chk("t2_b8_d0", 64'(dg(0)), 64'd1);
        chk("t2_b8_d2", 64'(dg(2)), 64'd9);
        chk("t2_b8_valid", 64'(diag_valid), 64'h7);
      end
    end
    wait_idle();
    tick();
    tick();
    chk("t2_cfg_err", 64'(cfg_err), 64'd0);
    chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t2_reads", 64'(memen_cnt - m0), 64'd72);

    // Diagonal overflow: rows of cr=2 map to k=22..26, last two dropped.
    m0 = memen_cnt;
    start_run(5, 1, 1, 11, 1, 3);
    wait_beat(lat);
    chk("t3_b0_valid", 64'(diag_valid), 64'h1F);
    wait_beat(lat);
    chk("t3_b1_valid", 64'(diag_valid), 64'hF800);
    chk("t3_b1_d11", 64'(dg(11)), 64'd5);
    chk("t3_b1_err", 64'(cfg_err), 64'd0);
    wait_beat(lat);
    chk("t3_b2_valid", 64'(diag_valid), 64'h1C00000);
    chk("t3_b2_d22", 64'(dg(22)), 64'd10);
    chk("t3_b2_d24", 64'(dg(24)), 64'd12);
    wait_idle();
    tick();
    chk("t3_cfg_err", 64'(cfg_err), 64'd1);
    chk("t3_reads", 64'(memen_cnt - m0), 64'd15);

    // Back-pressure hold, ignored start/config, then abort from OUT.
    out_ready = 1'b0;
    d0 = done_cnt;
    start_run(3, 4, 2, 3, 1, 1);
    wait_beat(lat);
    H = 16'd9;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("t4_hold_c%0d", c), {15'd0, mem_en, out_valid, dg(0), dg(1), dg(2)},
          {15'd0, 1'b0, 1'b1, 16'd0, 16'd4, 16'd8});
    end
    chk("t4_hold_valid", 64'(diag_valid), 64'h7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_idle", {61'd0, busy, out_valid, mem_en}, 64'd0);
    tick();
    tick();
    tick();
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a fetch, then a clean restart.
    start_run(3, 4, 2, 3, 1, 1);
    tick();
    tick();
    chk("t5_pre_dvalid", 64'(diag_valid), 64'h1);
    chk("t5_pre_addr", {49'd0, mem_en, 14'(mem_addr)}, {49'd0, 1'b1, 14'd8});
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_status", {59'd0, busy, mem_en, out_valid, done, cfg_err}, 64'd0);
    chk("t5_rst_addr", 64'(mem_addr), 64'd0);
    chk("t5_rst_dvalid", 64'(diag_valid), 64'd0);
    chk("t5_rst_data", 64'(diag_data == '0), 64'd1);
    #1;
    rst = 1'b0;
    start_run(3, 4, 2, 3, 1, 1);
    chk("t5_restart_addr", {49'd0, mem_en, 14'(mem_addr)}, {49'd0, 1'b1, 14'd0});
    wait_beat(lat);
    chk("t5_b0_d0", 64'(dg(0)), 64'd0);
    chk("t5_b0_d1", 64'(dg(1)), 64'd4);
    chk("t5_b0_d2", 64'(dg(2)), 64'd8);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Degenerate config S > W goes straight to FIN.
    d0 = done_cnt; m0 = memen_cnt;
    start_run(3, 4, 5, 3, 1, 1);
    chk("t6_fin", {61'd0, done, busy, mem_en}, {61'd0, 1'b0, 1'b1, 1'b0});
    tick();
    chk("t6_done", {61'd0, done, busy, cfg_err}, {61'd0, 1'b1, 1'b0, 1'b1});
    tick();
    chk("t6_after", {62'd0, done, cfg_err}, {62'd0, 1'b0, 1'b1});
    chk("t6_no_reads", 64'(memen_cnt - m0), 64'd0);
    chk("t6_one_done", 64'(done_cnt - d0), 64'd1);
    start_run(3, 4, 2, 3, 1, 1);
    chk("t6_err_cleared", 64'(cfg_err), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
